ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit: the initiator side of the instruction RAM read port. It drives a program counter into the RAM address/enable/read-write lines and captures the registered read data one cycle later. Captured instruction words are buffered with their PCs and handed to the decode stage over a valid/ready handshake. It sits between the instruction RAM and the accumulator-processor decoder; the decoder or branch logic redirects it through `redirect`.

## Interface
- `D_WIDTH`, 16, instruction word width; matches the instruction RAM data width
- `A_WIDTH`, 8, instruction address width; 2**A_WIDTH words
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  clock; all state updates on posedge
- `clr`  in  1  reset, asynchronous, active-high
- `mem_enab`  out  1  RAM chip enable; 1 = read request this cycle
- `mem_rw`  out  1  RAM read/write select; constant 0 (read)
- `mem_addr`  out  A_WIDTH  RAM address; equals `fetch_pc`
- `mem_data`  in  D_WIDTH  RAM registered read data, valid the cycle after a request
- `redirect`  in  1  load new PC, flush buffered and in-flight words
- `redirect_pc`  in  A_WIDTH  target PC for `redirect`
- `instr_valid`  out  1  `instr`/`instr_pc` hold a valid word
- `instr`  out  D_WIDTH  instruction word at FIFO head
- `instr_pc`  out  A_WIDTH  address the head word was fetched from
- `instr_ready`  in  1  decoder accepts the head word when `instr_valid` is 1
- `halted`  out  1  fetch stopped on a halt word (see Configuration)

## Operation
- State:
  - `fetch_pc` (A_WIDTH).
  - `inflight` (1 bit): a request was issued last cycle.
  - `kill` (1 bit): discard the in-flight response.
  - 3-entry FIFO of {word, pc}; `occ` 0..3.
- Issue condition: `!clr && !halted && !redirect && (occ + inflight) < 3`.
  - `mem_enab` = issue (combinational).
  - `mem_addr` = `fetch_pc`.
  - On issue, `fetch_pc` increments mod 2**A_WIDTH (255 -> 0, no flag) and `inflight` is set to 1 next cycle.
- Capture: when `inflight && !kill`, `mem_data` and the request PC (held in a register) are pushed into the FIFO.
  - `mem_data` is ignored in every other cycle; the RAM drives filler when disabled.
- Pop: when `instr_valid && instr_ready`. Push and pop may occur in the same cycle; `occ` is unchanged.
- The credit rule guarantees a push never finds the FIFO full. Overflow is unreachable and needs no handling.
- Redirect (highest priority after `clr`):
  - The FIFO is flushed (`occ` <- 0).
  - `kill` is set if `inflight`, so the next-cycle response is dropped.
  - `fetch_pc` <- `redirect_pc`; `halted` <- 0.
  - No issue occurs in the redirect cycle.
  - A pop in the same cycle still counts as accepted by the decoder; that word is not re-delivered.
- `instr`/`instr_pc` show the FIFO head. They are 0 when `occ`=0.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, `occ`=0, `inflight`=0, `kill`=0, `halted`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `mem_enab`=0 while `clr`=1, `mem_rw`=0.
- First request in the first cycle after `clr` falls.
- Latency: request in cycle N, `mem_data` valid in N+1, pushed at end of N+1, `instr_valid`=1 in N+2.
- Throughput: one word per cycle with `instr_ready` held at 1. Occupancy plus in-flight settles at 2, below the credit limit of 3.
- Stall: with `instr_ready`=0, at most 3 words are buffered; `mem_enab` stays 0 until a pop.
- First request after `redirect` occurs the cycle after `redirect`. The target word reaches `instr_valid` 3 cycles after the redirect cycle.
- `clr` asserted mid-operation: all state returns to reset values immediately. A pending RAM response is never captured because `inflight` is cleared.

## Configuration
- Macro: `IFETCH_HALT_EN`.
- Defined:
  - A pushed word whose top 4 bits equal 4'hF sets `halted` the next cycle.
  - Issue stops; any in-flight response following the halt word is dropped via `kill`.
  - The halt word itself is delivered to the decoder.
  - Only `redirect` or `clr` clears `halted`.
- Undefined: `halted` is tied 0, and 4'hF-opcode words are fetched like any other word.

## Test plan
- Reset release with `RESET_PC`=0, RAM[0..3]=0x000F,0x003F,0x007F,0x00EF, `instr_ready`=1 -> `mem_enab`=1 from cycle 0; `instr`=0x000F, `instr_pc`=0 in cycle 2; then one word per cycle in order.
- Hold `instr_ready`=0 for 6 cycles after first valid -> `mem_enab` low once occ+inflight=3; 3 words buffered; on release, words delivered in order with no loss or duplicate.
- `redirect`=1 with `redirect_pc`=0x40 while FIFO holds 2 words and 1 in flight -> the in-flight word is dropped; next `instr_pc`=0x40, 3 cycles after the redirect cycle.
- Start fetch at 0xFE -> `instr_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- `clr` pulse mid-stream with FIFO non-empty -> `instr_valid`=0, `mem_enab`=0 immediately; fetch resumes from `RESET_PC`.
- `IFETCH_HALT_EN` defined, RAM[2]=0xF000 -> words 0, 1 and 2 delivered; `halted`=1; no further `mem_enab`; a `redirect` to 0 clears `halted` and restarts fetch.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: issues PCs to the instruction RAM and buffers returned words for decode.
// Optional halt-on-0xF-opcode behaviour is enabled by defining IFETCH_HALT_EN.
module ifetch #(
  parameter int                  D_WIDTH  = 16,
  parameter int                  A_WIDTH  = 8,
  parameter logic [A_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               clr,
  output logic               mem_enab,
  output logic               mem_rw,
  output logic [A_WIDTH-1:0] mem_addr,
  input  logic [D_WIDTH-1:0] mem_data,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               instr_valid,
  output logic [D_WIDTH-1:0] instr,
  output logic [A_WIDTH-1:0] instr_pc,
  input  logic               instr_ready,
  output logic               halted
);

  localparam int DEPTH = 3;

  logic [A_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [A_WIDTH-1:0] req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic               kill_q, kill_d;
  logic [1:0]         occ_q, occ_d;
  logic [1:0]         rd_ptr_q, rd_ptr_d;
  logic [1:0]         wr_ptr_q, wr_ptr_d;
  logic [D_WIDTH-1:0] word_q [DEPTH];
  logic [D_WIDTH-1:0] word_d [DEPTH];
  logic [A_WIDTH-1:0] pc_q   [DEPTH];
  logic [A_WIDTH-1:0] pc_d   [DEPTH];

  logic halted_q;
  logic issue;
  logic push;
  logic pop;
  logic halt_hit;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts words already buffered plus the one still coming back from RAM.
  assign issue = !halted_q && !redirect &&
                 (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
  assign push  = inflight_q && !kill_q && !redirect;
  assign pop   = instr_valid && instr_ready;

`ifdef IFETCH_HALT_EN
  logic halted_d;

  assign halt_hit = push && (mem_data[D_WIDTH-1 -: 4] == 4'hF);

  always_comb begin
    halted_d = halted_q;
    if (redirect) begin
      halted_d = 1'b0;
    end else if (halt_hit) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign halt_hit = 1'b0;
  assign halted_q = 1'b0;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    kill_d     = 1'b0;
    occ_d      = occ_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (issue) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + A_WIDTH'(1);
    end

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      kill_d     = inflight_q;
      occ_d      = 2'd0;
      rd_ptr_d   = 2'd0;
      wr_ptr_d   = 2'd0;
    end else begin
      // A request issued alongside a halt word returns after it and must be dropped.
      kill_d = halt_hit && issue;
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      occ_q      <= 2'd0;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_comb begin
        word_d[gi] = word_q[gi];
        pc_d[gi]   = pc_q[gi];
        if (push && (wr_ptr_q == 2'(gi))) begin
          word_d[gi] = mem_data;
          pc_d[gi]   = req_pc_q;
        end
      end

      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          word_q[gi] <= '0;
          pc_q[gi]   <= '0;
        end else begin
          word_q[gi] <= word_d[gi];
          pc_q[gi]   <= pc_d[gi];
        end
      end
    end
  endgenerate

  assign instr_valid = (occ_q != 2'd0);
  assign instr       = instr_valid ? word_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr_q] : '0;
  assign mem_enab    = issue && !clr;
  assign mem_rw      = 1'b0;
  assign mem_addr    = fetch_pc_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: a registered-read RAM model plus an in-order stream reference model.
// Define IFETCH_HALT_EN for both bench and RTL to exercise the halt feature.
module tb_ifetch;

  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          mem_enab;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready = 1'b1;
  logic          halted;

  logic [DW-1:0] ram [256];
  logic [AW-1:0] exp_pc = '0;
  int n_checks = 0;
  int n_fail   = 0;

  ifetch #(.D_WIDTH(DW), .A_WIDTH(AW), .RESET_PC(8'h00)) dut (
    .clk(clk), .clr(clr), .mem_enab(mem_enab), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  // RAM: registered read; drives junk when not enabled.
  always @(posedge clk) begin
    if (mem_enab) mem_data <= ram[mem_addr];
    else          mem_data <= 16'($urandom);
  end

  // Stream model: every accepted word is the next consecutive address since the last restart.
  always @(negedge clk) begin
    if (clr) begin
      exp_pc = 8'h00;
    end else begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (instr_pc !== exp_pc || instr !== ram[exp_pc]) begin
          n_fail++;
          $display("FAIL stream got pc=%h word=%h exp pc=%h word=%h",
                   instr_pc, instr, exp_pc, ram[exp_pc]);
        end
        exp_pc = exp_pc + 8'h01;
      end
      if (redirect) exp_pc = redirect_pc;
    end
  end

  task automatic hold_reset();
    @(posedge clk); #1;
    clr = 1'b1;
    redirect = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] tp [4];
    tp = '{16'h000F, 16'h003F, 16'h007F, 16'h00EF};
    clr = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    n_checks++; if (mem_enab !== 1'b0) begin n_fail++; $display("FAIL rst_enab got %b exp 0", mem_enab); end
    n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL rst_instr got %h exp 0000", instr); end
    n_checks++; if (instr_pc !== 8'h00) begin n_fail++; $display("FAIL rst_pc got %h exp 00", instr_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b exp 0", halted); end
    n_checks++; if (mem_rw !== 1'b0) begin n_fail++; $display("FAIL rst_rw got %b exp 0", mem_rw); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      if (c < 2) begin
        n_checks++;
        if ({mem_enab, mem_addr, instr_valid} !== {1'b1, 8'(c), 1'b0}) begin
          n_fail++;
          $display("FAIL start_c%0d got enab=%b addr=%h valid=%b exp 1 %h 0", c, mem_enab, mem_addr, instr_valid, 8'(c));
        end
      end else begin
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 8'(c - 2), tp[c - 2]}) begin
          n_fail++;
          $display("FAIL first_words_c%0d got valid=%b pc=%h word=%h exp 1 %h %h",
                   c, instr_valid, instr_pc, instr, 8'(c - 2), tp[c - 2]);
        end
      end
      $display("reset_seq cycle %0d enab=%b valid=%b pc=%h instr=%h", c, mem_enab, instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_stall();
    int en = 0;
    int pops = 0;
    hold_reset();
    instr_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      clr = 1'b0;
      @(negedge clk);
      if (mem_enab) en++;
    end
    n_checks++; if (en !== 3) begin n_fail++; $display("FAIL stall_issues got %0d exp 3", en); end
    n_checks++; if ({mem_enab, instr_valid, instr_pc} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++; $display("FAIL stall_state got enab=%b valid=%b pc=%h exp 0 1 00", mem_enab, instr_valid, instr_pc);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      instr_ready = 1'b1;
      @(negedge clk);
      if (instr_valid && instr_ready) pops++;
    end
    n_checks++; if (pops !== 8) begin n_fail++; $display("FAIL stall_release_pops got %0d exp 8", pops); end
    $display("stall issues=%0d pops_after_release=%0d", en, pops);
  endtask

  task automatic test_redirect();
    hold_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      clr = 1'b0;
      instr_ready = (c != 5) && (c != 6);
      redirect = (c == 6);
      redirect_pc = 8'h40;
      @(negedge clk);
    end
    n_checks++; if ({instr_valid, mem_enab} !== 2'b10) begin
      n_fail++; $display("FAIL redir_cycle got valid=%b enab=%b exp 1 0", instr_valid, mem_enab);
    end
    for (int r = 1; r <= 3; r++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      instr_ready = 1'b1;
      @(negedge clk);
      if (r == 1) begin
        n_checks++; if ({mem_enab, mem_addr} !== {1'b1, 8'h40}) begin
          n_fail++; $display("FAIL redir_issue got enab=%b addr=%h exp 1 40", mem_enab, mem_addr);
        end
      end
      if (r < 3) begin
        n_checks++; if (instr_valid !== 1'b0) begin
          n_fail++; $display("FAIL redir_flush_r%0d got valid=%b exp 0", r, instr_valid);
        end
      end else begin
        n_checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 8'h40, ram[8'h40]}) begin
          n_fail++; $display("FAIL redir_target got valid=%b pc=%h word=%h exp 1 40 %h",
                             instr_valid, instr_pc, instr, ram[8'h40]);
        end
      end
    end
    $display("redirect target pc=%h word=%h", instr_pc, instr);
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_seq [4];
    logic [AW-1:0] got [4];
    int n = 0;
    exp_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 8'hFE; instr_ready = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (instr_valid) begin got[n] = instr_pc; n++; end
      if (n < 4) begin @(posedge clk); #1; end
    end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL wrap_timeout got %0d words exp 4", n); end
    for (int i = 0; i < n; i++) begin
      n_checks++; if (got[i] !== exp_seq[i]) begin
        n_fail++; $display("FAIL wrap_pc%0d got %h exp %h", i, got[i], exp_seq[i]);
      end
      $display("wrap word %0d pc=%h", i, got[i]);
    end
  endtask

  task automatic test_clr_midstream();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      instr_ready = 1'b0;
    end
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL clr_pre_valid got %b exp 1", instr_valid); end
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    n_checks++; if ({instr_valid, mem_enab, instr} !== {1'b0, 1'b0, 16'h0000}) begin
      n_fail++; $display("FAIL clr_mid got valid=%b enab=%b instr=%h exp 0 0 0000", instr_valid, mem_enab, instr);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      clr = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      if (c == 0) begin
        n_checks++; if ({mem_enab, mem_addr} !== {1'b1, 8'h00}) begin
          n_fail++; $display("FAIL clr_resume got enab=%b addr=%h exp 1 00", mem_enab, mem_addr);
        end
      end
    end
    n_checks++; if ({instr_valid, instr_pc} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL clr_first got valid=%b pc=%h exp 1 00", instr_valid, instr_pc);
    end
    $display("clr_midstream resumed pc=%h", instr_pc);
  endtask

  task automatic test_random();
    int pops = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      clr = ($urandom_range(0, 99) == 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect = !clr && ($urandom_range(0, 19) == 0);
      redirect_pc = 8'($urandom);
      @(negedge clk);
      if (instr_valid && instr_ready && !clr) pops++;
      if (redirect || clr) begin
        n_checks++; if (mem_enab !== 1'b0) begin
          n_fail++; $display("FAIL rand_no_issue c%0d got enab=%b exp 0", c, mem_enab);
        end
      end
    end
    @(posedge clk); #1;
    clr = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    n_checks++; if (pops < 100) begin n_fail++; $display("FAIL rand_throughput got %0d pops exp >=100", pops); end
    $display("random pops=%0d", pops);
  endtask

  task automatic test_halt();
    int en = 0;
    int en_late = 0;
    int pops = 0;
    hold_reset();
    ram[2] = 16'hF000;
    instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      clr = 1'b0;
      @(negedge clk);
      if (mem_enab) en++;
      if (mem_enab && c >= 5) en_late++;
      if (instr_valid) pops++;
    end
`ifdef IFETCH_HALT_EN
    n_checks++; if (pops !== 3) begin n_fail++; $display("FAIL halt_pops got %0d exp 3", pops); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag got %b exp 1", halted); end
    n_checks++; if (en !== 4 || en_late !== 0) begin
      n_fail++; $display("FAIL halt_issues got %0d late %0d exp 4 late 0", en, en_late);
    end
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 8'h00;
    @(negedge clk);
    n_checks++; if (mem_enab !== 1'b0) begin n_fail++; $display("FAIL halt_redir_cycle got enab=%b exp 0", mem_enab); end
    pops = 0;
    for (int r = 1; r <= 6; r++) begin
      @(posedge clk); #1;
      redirect = 1'b0;
      @(negedge clk);
      if (r == 1) begin
        n_checks++; if ({halted, mem_enab, mem_addr} !== {1'b0, 1'b1, 8'h00}) begin
          n_fail++; $display("FAIL halt_restart got halted=%b enab=%b addr=%h exp 0 1 00", halted, mem_enab, mem_addr);
        end
      end
      if (instr_valid) pops++;
    end
    n_checks++; if (pops !== 3) begin n_fail++; $display("FAIL halt_repops got %0d exp 3", pops); end
`else
    n_checks++; if (pops !== 10) begin n_fail++; $display("FAIL nohalt_pops got %0d exp 10", pops); end
    n_checks++; if (halted !== 1'b0 || en_late !== 7) begin
      n_fail++; $display("FAIL nohalt_state got halted=%b late_issues=%0d exp 0 7", halted, en_late);
    end
`endif
    $display("halt test issues=%0d pops=%0d halted=%b", en, pops, halted);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      w[15:12] = 4'($urandom_range(0, 14));
      ram[i] = w;
    end
    ram[0] = 16'h000F; ram[1] = 16'h003F; ram[2] = 16'h007F; ram[3] = 16'h00EF;
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_clr_midstream();
    test_random();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
